fifo_byte_serializer: RTL and testbench
=======================================

# fifo_byte_serializer

Drains 32-bit words from the synchronous FIFO's read port and emits them as a byte stream on a valid/ready interface, most significant byte first. Words are grouped into fixed-length packets, and the final byte of each packet is flagged with `m_last`. The block sits directly downstream of the FIFO and is the only driver of its read enable.

## Interface
- `FIFO_WIDTH`, default 32: FIFO word width; must be a multiple of 8 and ≥ 8; BYTES = FIFO_WIDTH/8.
- `PKT_WORDS`, default 4: words per packet; must be ≥ 1.
- `CNT_W`, default 8: width of `word_cnt` and `pkt_cnt`; must satisfy 2^CNT_W ≥ PKT_WORDS.

Ports:
- `clk` input 1: single clock; everything is on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `enable` input 1: allows new word fetches.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_rden` output 1: FIFO read enable (combinational).
- `fifo_rddata` input FIFO_WIDTH: FIFO read data, valid the cycle after `fifo_rden`.
- `m_data` output 8: byte out.
- `m_valid` output 1: byte valid.
- `m_ready` input 1: downstream accepts the byte.
- `m_last` output 1: final byte of a packet.
- `busy` output 1: state ≠ IDLE.
- `word_cnt` output CNT_W: word index within the current packet.
- `pkt_cnt` output CNT_W: packets completed; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, WAIT, SEND.
- IDLE:
  - `fifo_rden` = `enable` && !`fifo_empty`.
  - If `fifo_rden` is high, go to WAIT; otherwise stay in IDLE.
  - `fifo_rden` is 0 in every other state.
- WAIT:
  - Capture `fifo_rddata` into shift register `shreg`.
  - Clear `byte_idx` (width clog2(BYTES), minimum 1).
  - Go to SEND unconditionally.
- SEND:
  - `m_valid` = 1; `m_data` = `shreg`[FIFO_WIDTH-1 -: 8].
  - `m_last` = (`byte_idx` == BYTES-1) && (`word_cnt` == PKT_WORDS-1).
  - A handshake (`m_valid` && `m_ready`) with `byte_idx` < BYTES-1: shift `shreg` left by 8 and increment `byte_idx`.
  - A handshake with `byte_idx` == BYTES-1:
    - If `word_cnt` == PKT_WORDS-1: `word_cnt` ← 0 and `pkt_cnt` ← `pkt_cnt`+1.
    - Otherwise: `word_cnt` ← `word_cnt`+1.
    - Go to IDLE.
- Backpressure: while `m_valid` && !`m_ready`, `m_data`, `m_last`, `shreg` and `byte_idx` hold.
- Dropping `enable` mid-word does not abort. The current word finishes, and fetching stops at the next IDLE.
- With BYTES == 1 the first SEND byte is the last byte; no shift occurs.
- Every fetched word is emitted exactly once, in FIFO order; no byte is dropped or duplicated.

## Timing
- Reset (`rst_n` low at an edge) forces:
  - state = IDLE, `m_valid` = 0, `m_last` = 0, `m_data` = 0, `busy` = 0, `fifo_rden` = 0;
  - `word_cnt` = 0, `pkt_cnt` = 0, `shreg` = 0, `byte_idx` = 0.
- Reset mid-word discards the partial word. A packet in progress restarts at `word_cnt` 0, and no `m_last` is generated for it.
- Latency: `fifo_rden` high in cycle N → WAIT in N+1 → first byte with `m_valid` high in N+2.
- Throughput with `m_ready` held high: one word per BYTES+2 cycles. This is 6 cycles for 32 bits, e.g. 8 words take 48 cycles.
- `fifo_rden` never asserts while `fifo_empty` = 1, so the FIFO's empty guard is never relied on.
- `m_valid` never drops without a handshake.
- `fifo_rden` depends only on state, `enable` and `fifo_empty`; there is no combinational path from `m_ready`.

## Test plan
- Single word, ready always high: FIFO holds 0xA1B2C3D4 → `fifo_rden` is a 1-cycle pulse. `m_data` is A1, B2, C3, D4 on 4 consecutive cycles starting 2 cycles after the pulse. `m_last` stays 0 and `word_cnt` ends at 1.
- Packet framing, PKT_WORDS=4: write words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F → bytes 00..0F in order. `m_last` is high only with byte 0F; then `pkt_cnt` = 1 and `word_cnt` = 0.
- Backpressure: 0xDEADBEEF with `m_ready` low for 3 cycles during byte BE → `m_data` holds BE with `m_valid` high for 4 cycles, then EF follows. Nothing is lost or duplicated.
- Empty and enable gating:
  - FIFO empty → `fifo_rden` stays 0 and `m_valid` stays 0 indefinitely.
  - `enable` = 0 with 2 words queued → no fetch.
  - `enable` dropped mid-word → the remaining bytes of that word complete, then `busy` = 0.
- Reset mid-word: assert `rst_n` low during byte B2 of 0xA1B2C3D4 → on the next edge all outputs take their reset values. After release the next FIFO word is emitted starting from its MSB, with `word_cnt` at 0.
- Stress: 64 random words, random `m_ready`, concurrent FIFO writes → a scoreboard sees the exact MSB-first byte sequence, `m_last` every 16th byte, and final `pkt_cnt` = 16.

Source files
------------

// File: rtl/fifo_byte_serializer.sv
// Pulls words from a synchronous FIFO and emits them MSB-first as a byte stream
// on a valid/ready interface, flagging the last byte of every PKT_WORDS-word packet.
module fifo_byte_serializer #(
  parameter int FIFO_WIDTH = 32,
  parameter int PKT_WORDS  = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rden,
  input  logic [FIFO_WIDTH-1:0] fifo_rddata,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_W-1:0]      word_cnt,
  output logic [CNT_W-1:0]      pkt_cnt
);

  localparam int BYTES  = FIFO_WIDTH / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(PKT_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [FIFO_WIDTH-1:0]   shreg;
  logic [BIDX_W-1:0]       byte_idx;
  logic                    handshake;
  logic                    last_byte;
  logic                    last_word;

  assign last_byte = (byte_idx == LAST_BYTE);
  assign last_word = (word_cnt == LAST_WORD);

  always_comb begin
    state_nxt = state;
    fifo_rden = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    busy      = 1'b1;
    m_data    = shreg[FIFO_WIDTH-1 -: 8];
    handshake = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        // Read enable never looks at m_ready, so no ready-to-rden path exists.
        fifo_rden = enable && !fifo_empty;
        if (fifo_rden) state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt = SEND;
      end
      SEND: begin
        m_valid   = 1'b1;
        m_last    = last_byte && last_word;
        handshake = m_ready;
        if (m_ready && last_byte) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      byte_idx <= '0;
      word_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT) begin
        shreg    <= fifo_rddata;
        byte_idx <= '0;
      end else if (handshake) begin
        if (!last_byte) begin
          shreg    <= shreg << 8;
          byte_idx <= byte_idx + BIDX_W'(1);
        end else if (last_word) begin
          word_cnt <= '0;
          pkt_cnt  <= pkt_cnt + CNT_W'(1);
        end else begin
          word_cnt <= word_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed and randomised checks of fifo_byte_serializer against a bench FIFO model.
module tb_fifo_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_empty;
  logic        fifo_rden;
  logic [31:0] fifo_rddata = '0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        busy;
  logic [7:0]  word_cnt;
  logic [7:0]  pkt_cnt;

  fifo_byte_serializer #(.FIFO_WIDTH(32), .PKT_WORDS(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rden(fifo_rden), .fifo_rddata(fifo_rddata), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy),
    .word_cnt(word_cnt), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  // Bench FIFO: written by the stimulus process, read on fifo_rden.
  logic [31:0] mem [1024];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          underflows = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rden) begin
      if (wr_ptr == rd_ptr) underflows <= underflows + 1;
      else begin
        fifo_rddata <= mem[rd_ptr[9:0]];
        rd_ptr      <= rd_ptr + 1;
      end
    end
  end

  int          errors = 0;
  int          checks = 0;
  int          cycles;
  bit          timed_out;
  logic [7:0]  got[$];
  bit          gotlast[$];
  logic [31:0] pending[$];
  logic [31:0] words[$];

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr[9:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs from a falling edge until FIFO, pending list and DUT are all idle.
  task automatic collect(input int max_cycles, input bit rnd);
    cycles = 0;
    timed_out = 1'b0;
    forever begin
      if (wr_ptr == rd_ptr && pending.size() == 0 && !busy) break;
      if (cycles >= max_cycles) begin
        timed_out = 1'b1;
        break;
      end
      m_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        gotlast.push_back(m_last);
      end
      if (rnd && pending.size() > 0 && $urandom_range(1) == 1) push_word(pending.pop_front());
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", m_last); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fifo_rden !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b want 0", fifo_rden); end
    checks++; if (word_cnt !== 8'd0 || pkt_cnt !== 8'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", word_cnt, pkt_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [7:0] e [4];
    e[0] = 8'hA1; e[1] = 8'hB2; e[2] = 8'hC3; e[3] = 8'hD4;
    enable = 1'b1; m_ready = 1'b1;
    push_word(32'hA1B2C3D4);
    #1;
    checks++; if (fifo_rden !== 1'b1) begin errors++; $display("FAIL single_rden_pulse: got %b want 1", fifo_rden); end
    @(negedge clk);
    checks++; if (fifo_rden !== 1'b0 || busy !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL single_wait: rden=%b busy=%b valid=%b want 0 1 0", fifo_rden, busy, m_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (m_valid !== 1'b1 || m_data !== e[i] || m_last !== 1'b0) begin
        errors++; $display("FAIL single_byte%0d: valid=%b data=%h last=%b want 1 %h 0", i, m_valid, m_data, m_last, e[i]); end
    end
    @(negedge clk);
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== 8'd1) begin
      errors++; $display("FAIL single_end: valid=%b busy=%b word_cnt=%0d want 0 0 1", m_valid, busy, word_cnt); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] e [4];
    e[0] = 8'h11; e[1] = 8'h22; e[2] = 8'h33; e[3] = 8'h44;
    enable = 1'b1; m_ready = 1'b1;
    push_word(32'hA1B2C3D4);
    push_word(32'h11223344);
    for (int i = 0; i < 10 && !(m_valid && m_data == 8'hB2); i++) @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hB2) begin
      errors++; $display("FAIL rstmid_reach_b2: valid=%b data=%h want 1 b2", m_valid, m_data); end
    rst_n = 1'b0; enable = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00 || busy !== 1'b0 || fifo_rden !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: valid=%b last=%b data=%h busy=%b rden=%b want 0 0 00 0 0", m_valid, m_last, m_data, busy, fifo_rden); end
    checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_word_cnt: got %0d want 0", word_cnt); end
    rst_n = 1'b1; enable = 1'b1;
    got.delete(); gotlast.delete();
    collect(40, 1'b0);
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL rstmid_count: got %0d bytes want 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== e[i]) begin errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, got[i], e[i]); end
    end
    checks++; if (word_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_word_after: got %0d want 1", word_cnt); end
  endtask

  task automatic test_packet();
    int bad;
    int lasts;
    pulse_reset();
    enable = 1'b1; m_ready = 1'b1;
    push_word(32'h00010203); push_word(32'h04050607);
    push_word(32'h08090A0B); push_word(32'h0C0D0E0F);
    got.delete(); gotlast.delete();
    collect(100, 1'b0);
    checks++; if (timed_out !== 1'b0 || cycles !== 24) begin
      errors++; $display("FAIL packet_throughput: timeout=%b cycles=%0d want 0 24", timed_out, cycles); end
    checks++; if (got.size() !== 16) begin errors++; $display("FAIL packet_count: got %0d want 16", got.size()); end
    bad = 0; lasts = 0;
    for (int i = 0; i < got.size(); i++) begin
      if (got[i] !== 8'(i)) bad++;
      if (gotlast[i]) lasts++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL packet_bytes: got %0d wrong bytes want 0", bad); end
    checks++; if (lasts !== 1 || got.size() != 16 || gotlast[15] !== 1'b1) begin
      errors++; $display("FAIL packet_last: got %0d last flags want 1 on byte 0f", lasts); end
    checks++; if (pkt_cnt !== 8'd1 || word_cnt !== 8'd0) begin
      errors++; $display("FAIL packet_counts: pkt=%0d word=%0d want 1 0", pkt_cnt, word_cnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0] e [4];
    int be_cycles;
    int stall;
    int lasts;
    e[0] = 8'hDE; e[1] = 8'hAD; e[2] = 8'hBE; e[3] = 8'hEF;
    be_cycles = 0; stall = 0; lasts = 0;
    enable = 1'b1; m_ready = 1'b1;
    push_word(32'hDEADBEEF);
    got.delete(); gotlast.delete();
    for (int i = 0; i < 20; i++) begin
      if (m_valid && m_data == 8'hBE && stall < 3) begin
        m_ready = 1'b0; stall++;
      end else m_ready = 1'b1;
      if (m_valid && m_data == 8'hBE) be_cycles++;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        if (m_last) lasts++;
      end
      if (got.size() == 4) break;
      @(negedge clk);
    end
    @(negedge clk);
    m_ready = 1'b1;
    checks++; if (be_cycles !== 4) begin errors++; $display("FAIL bp_hold_cycles: got %0d want 4", be_cycles); end
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== e[i]) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", i, got[i], e[i]); end
    end
    checks++; if (lasts !== 0 || word_cnt !== 8'd1) begin
      errors++; $display("FAIL bp_framing: lasts=%0d word_cnt=%0d want 0 1", lasts, word_cnt); end
  endtask

  task automatic test_gating();
    int viol;
    logic [7:0] e [8];
    e[0] = 8'h55; e[1] = 8'h66; e[2] = 8'h77; e[3] = 8'h88;
    e[4] = 8'h99; e[5] = 8'hAA; e[6] = 8'hBB; e[7] = 8'hCC;
    enable = 1'b1; m_ready = 1'b1; viol = 0;
    repeat (8) begin
      @(negedge clk);
      if (fifo_rden || m_valid) viol++;
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL gate_empty: got %0d active cycles want 0", viol); end
    enable = 1'b0;
    push_word(32'h55667788); push_word(32'h99AABBCC);
    viol = 0;
    repeat (8) begin
      @(negedge clk);
      if (fifo_rden || m_valid) viol++;
    end
    checks++; if (viol !== 0 || (wr_ptr - rd_ptr) !== 2) begin
      errors++; $display("FAIL gate_disabled: active=%0d queued=%0d want 0 2", viol, wr_ptr - rd_ptr); end
    enable = 1'b1;
    #1;
    checks++; if (fifo_rden !== 1'b1) begin errors++; $display("FAIL gate_fetch: got rden %b want 1", fifo_rden); end
    @(negedge clk);
    enable = 1'b0;
    got.delete();
    for (int i = 0; i < 12; i++) begin
      if (m_valid && m_ready) got.push_back(m_data);
      if (!busy && got.size() > 0) break;
      @(negedge clk);
    end
    viol = 0;
    repeat (5) begin
      if (fifo_rden || busy) viol++;
      @(negedge clk);
    end
    checks++; if (viol !== 0 || (wr_ptr - rd_ptr) !== 1) begin
      errors++; $display("FAIL gate_stop: active=%0d queued=%0d want 0 1", viol, wr_ptr - rd_ptr); end
    enable = 1'b1;
    collect(40, 1'b0);
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL gate_count: got %0d want 8", got.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== e[i]) begin errors++; $display("FAIL gate_byte%0d: got %h want %h", i, got[i], e[i]); end
    end
    checks++; if (word_cnt !== 8'd3) begin errors++; $display("FAIL gate_word_cnt: got %0d want 3", word_cnt); end
  endtask

  task automatic test_stress();
    int bad_data;
    int bad_last;
    logic [31:0] w;
    pulse_reset();
    words.delete(); pending.delete();
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      words.push_back(w);
      if (i < 8) push_word(w);
      else pending.push_back(w);
    end
    enable = 1'b1;
    got.delete(); gotlast.delete();
    collect(5000, 1'b1);
    m_ready = 1'b1;
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL stress_timeout: ran %0d cycles without draining", cycles); end
    checks++; if (got.size() !== 256) begin errors++; $display("FAIL stress_count: got %0d bytes want 256", got.size()); end
    bad_data = 0; bad_last = 0;
    for (int i = 0; i < got.size() && i < 256; i++) begin
      w = words[i / 4];
      if (got[i] !== w[31 - 8 * (i % 4) -: 8]) bad_data++;
      if (gotlast[i] !== ((i % 16) == 15)) bad_last++;
    end
    checks++; if (bad_data !== 0) begin errors++; $display("FAIL stress_bytes: got %0d wrong bytes want 0", bad_data); end
    checks++; if (bad_last !== 0) begin errors++; $display("FAIL stress_last: got %0d misplaced last flags want 0", bad_last); end
    checks++; if (pkt_cnt !== 8'd16 || word_cnt !== 8'd0) begin
      errors++; $display("FAIL stress_counts: pkt=%0d word=%0d want 16 0", pkt_cnt, word_cnt); end
    checks++; if (underflows !== 0) begin errors++; $display("FAIL rden_on_empty: got %0d reads of empty FIFO want 0", underflows); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_reset_mid_word();
    test_packet();
    test_backpressure();
    test_gating();
    test_stress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
